// File: rtl/lane_combiner.sv
// Re-pairs two 32-bit lane streams into 64-bit samples via per-lane FIFOs and
// checks the active/idle burst framing seen on lane 1.
module lane_combiner #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ACTIVE_SAMPLES = 3276,
  parameter int unsigned IDLE_SAMPLES   = 1176,
  parameter int unsigned TOTAL_SAMPLES  = 733824
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     port1_data,
  input  logic                  port1_valid,
  input  logic [DATA_W-1:0]     port2_data,
  input  logic                  port2_valid,
  output logic [2*DATA_W-1:0]   sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [1:0]            lane_ovf,
  output logic                  skew_err,
  output logic                  burst_done,
  output logic                  burst_err,
  output logic [31:0]           burst_count,
  output logic [31:0]           dbg_sample_idx
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned WCW = $clog2(ACTIVE_SAMPLES + 1);
  localparam int unsigned QCW = $clog2(IDLE_SAMPLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem1 [FIFO_DEPTH];
  logic [DATA_W-1:0] mem2 [FIFO_DEPTH];
  logic [PW-1:0]     wp1, rp1, wp2, rp2;
  logic              empty1, empty2, full1, full2;
  logic              pop, push1, push2, drop1, drop2;
  logic [31:0]       next_idx;

  state_t            state;
  logic [WCW-1:0]    wc;
  logic [QCW-1:0]    qc;
  logic [QCW-1:0]    qc_inc;

  // FIFO status; the extra pointer bit distinguishes full from empty
  always_comb begin
    empty1 = (wp1 == rp1);
    empty2 = (wp2 == rp2);
    full1  = (wp1[AW] != rp1[AW]) && (wp1[AW-1:0] == rp1[AW-1:0]);
    full2  = (wp2[AW] != rp2[AW]) && (wp2[AW-1:0] == rp2[AW-1:0]);
    pop    = !empty1 && !empty2 && (!sample_valid || sample_ready);
    push1  = port1_valid && (!full1 || pop);
    push2  = port2_valid && (!full2 || pop);
    drop1  = port1_valid && full1 && !pop;
    drop2  = port2_valid && full2 && !pop;
    qc_inc = qc + QCW'(1);
  end

  // Lane storage needs no reset: occupancy is defined by the pointers alone
  always_ff @(posedge clk) begin
    if (push1) mem1[wp1[AW-1:0]] <= port1_data;
    if (push2) mem2[wp2[AW-1:0]] <= port2_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp1      <= '0;
      rp1      <= '0;
      wp2      <= '0;
      rp2      <= '0;
      lane_ovf <= '0;
    end else begin
      if (push1) wp1 <= wp1 + PW'(1);
      if (push2) wp2 <= wp2 + PW'(1);
      if (pop) begin
        rp1 <= rp1 + PW'(1);
        rp2 <= rp2 + PW'(1);
      end
      if (drop1) lane_ovf[0] <= 1'b1;
      if (drop2) lane_ovf[1] <= 1'b1;
    end
  end

  // Output register: a popped pair loads directly; otherwise a transfer empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out     <= '0;
      sample_valid   <= 1'b0;
      dbg_sample_idx <= '0;
      next_idx       <= '0;
    end else if (pop) begin
      sample_out     <= {mem1[rp1[AW-1:0]], mem2[rp2[AW-1:0]]};
      sample_valid   <= 1'b1;
      dbg_sample_idx <= next_idx;
      next_idx       <= (next_idx == 32'(TOTAL_SAMPLES - 1)) ? 32'd0 : next_idx + 32'd1;
    end else if (sample_ready) begin
      sample_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) skew_err <= 1'b0;
    else     skew_err <= port1_valid ^ port2_valid;
  end

  // Burst framing monitor on lane 1; never affects the data path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wc          <= '0;
      qc          <= '0;
      burst_done  <= 1'b0;
      burst_err   <= 1'b0;
      burst_count <= '0;
    end else begin
      burst_done <= 1'b0;
      burst_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (port1_valid) begin
            state <= ST_ACTIVE;
            wc    <= WCW'(1);
          end
        end
        ST_ACTIVE: begin
          if (port1_valid) begin
            if (wc == WCW'(ACTIVE_SAMPLES - 1)) begin
              state       <= ST_GAP;
              qc          <= '0;
              burst_done  <= 1'b1;
              burst_count <= burst_count + 32'd1;
            end else begin
              wc <= wc + WCW'(1);
            end
          end
        end
        ST_GAP: begin
          if (port1_valid) begin
            burst_err <= 1'b1;
            state     <= ST_ACTIVE;
            wc        <= WCW'(1);
          end else begin
            qc <= qc_inc;
            if (qc_inc == QCW'(IDLE_SAMPLES - 1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_combiner.sv
// Scoreboard bench for lane_combiner: order-based pairing model, decoupled
// output monitor, directed framing/overflow/reset/wrap scenarios.
module tb_lane_combiner;

  localparam int unsigned ACT = 3276;
  localparam int unsigned IDL = 1176;
  localparam int unsigned TS  = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] port1_data = '0;
  logic        port1_valid = 1'b0;
  logic [31:0] port2_data = '0;
  logic        port2_valid = 1'b0;
  logic [63:0] sample_out;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic [1:0]  lane_ovf;
  logic        skew_err;
  logic        burst_done;
  logic        burst_err;
  logic [31:0] burst_count;
  logic [31:0] dbg_sample_idx;

  lane_combiner #(
    .DATA_W(32), .FIFO_DEPTH(8), .ACTIVE_SAMPLES(ACT),
    .IDLE_SAMPLES(IDL), .TOTAL_SAMPLES(TS)
  ) dut (
    .clk(clk), .rst(rst),
    .port1_data(port1_data), .port1_valid(port1_valid),
    .port2_data(port2_data), .port2_valid(port2_valid),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .lane_ovf(lane_ovf), .skew_err(skew_err), .burst_done(burst_done),
    .burst_err(burst_err), .burst_count(burst_count), .dbg_sample_idx(dbg_sample_idx)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_done = 0;
  int          n_err = 0;
  int          n_skew = 0;
  logic [31:0] lq1[$];
  logic [31:0] lq2[$];
  logic [63:0] exp_data[$];
  int unsigned exp_idx_q[$];
  int unsigned exp_idx = 0;
  bit          accept = 1'b1;
  int unsigned rdy_pct = 100;
  bit          hold_prev = 1'b0;
  logic [63:0] prev_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: lanes pair strictly in arrival order, one sample per pair
  task automatic drive(input logic v1, input logic [31:0] d1, input logic v2, input logic [31:0] d2);
    port1_valid  = v1;
    port1_data   = d1;
    port2_valid  = v2;
    port2_data   = d2;
    sample_ready = ($urandom_range(99) < rdy_pct);
    if (accept) begin
      if (v1) lq1.push_back(d1);
      if (v2) lq2.push_back(d2);
    end
    while (lq1.size() > 0 && lq2.size() > 0) begin
      exp_data.push_back({lq1.pop_front(), lq2.pop_front()});
      exp_idx_q.push_back(exp_idx);
      exp_idx = (exp_idx + 1) % TS;
    end
    cyc();
  endtask

  task automatic quiet(input int n);
    repeat (n) drive(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic burst(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, $urandom, 1'b1, $urandom);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    rdy_pct = 100;
    while ((exp_data.size() != 0 || sample_valid) && k < 500) begin
      drive(1'b0, 32'd0, 1'b0, 32'd0);
      k++;
    end
    chk(name, 64'(exp_data.size()), 64'd0);
  endtask

  task automatic clear_counts();
    n_done = 0;
    n_err  = 0;
    n_skew = 0;
  endtask

  // Monitor: consumes the scoreboard on every transfer, checks hold stability
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (burst_done) n_done++;
      if (burst_err)  n_err++;
      if (skew_err)   n_skew++;
      if (hold_prev) begin
        chk("hold_valid", 64'(sample_valid), 64'd1);
        chk("hold_data", sample_out, prev_out);
      end
      if (sample_valid && sample_ready) begin
        if (exp_data.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_sample: actual %0h required none", sample_out);
        end else begin
          chk("sample", sample_out, exp_data.pop_front());
          chk("sample_idx", 64'(dbg_sample_idx), 64'(exp_idx_q.pop_front()));
        end
      end
      hold_prev = sample_valid && !sample_ready;
      prev_out  = sample_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dq[$];
    logic        v;
    logic [31:0] a, b;

    repeat (3) cyc();
    chk("rst_valid", 64'(sample_valid), 64'd0);
    chk("rst_out", sample_out, 64'd0);
    chk("rst_ovf", 64'(lane_ovf), 64'd0);
    chk("rst_count", 64'(burst_count), 64'd0);
    chk("rst_idx", 64'(dbg_sample_idx), 64'd0);
    rst = 1'b0;
    cyc();

    // Aligned burst {i, ~i}
    clear_counts();
    for (int i = 0; i < int'(ACT); i++) begin
      drive(1'b1, 32'(i), 1'b1, ~32'(i));
      if (i == int'(ACT) - 2) chk("done_early", 64'(burst_done), 64'd0);
      if (i == int'(ACT) - 1) begin
        chk("done_pulse", 64'(burst_done), 64'd1);
        chk("count_a", 64'(burst_count), 64'd1);
      end
    end
    quiet(int'(IDL) + 24);
    drain("drain_a");
    chk("a_done", 64'(n_done), 64'd1);
    chk("a_err", 64'(n_err), 64'd0);
    chk("a_skew", 64'(n_skew), 64'd0);
    chk("a_ovf", 64'(lane_ovf), 64'd0);

    // Lane 2 delayed by three cycles
    clear_counts();
    for (int t = 0; t < int'(ACT) + 3; t++) begin
      v = (t < int'(ACT));
      a = $urandom;
      b = $urandom;
      if (v) dq.push_back(b);
      if (t >= 3) drive(v, v ? a : 32'd0, 1'b1, dq.pop_front());
      else        drive(v, a, 1'b0, 32'd0);
    end
    quiet(int'(IDL) + 24);
    drain("drain_b");
    chk("b_skew", 64'(n_skew), 64'd6);
    chk("b_done", 64'(n_done), 64'd1);
    chk("b_err", 64'(n_err), 64'd0);
    chk("b_count", 64'(burst_count), 64'd2);
    chk("b_ovf", 64'(lane_ovf), 64'd0);

    // Framing: early word in the gap, then a legal burst after a full gap
    clear_counts();
    burst(int'(ACT));
    chk("c_count1", 64'(burst_count), 64'd3);
    quiet(100);
    drive(1'b1, $urandom, 1'b1, $urandom);
    chk("gap_err", 64'(burst_err), 64'd1);
    burst(int'(ACT) - 1);
    chk("done_after_err", 64'(burst_done), 64'd1);
    chk("c_count2", 64'(burst_count), 64'd4);
    quiet(int'(IDL));
    burst(int'(ACT));
    chk("c_count3", 64'(burst_count), 64'd5);
    quiet(int'(IDL) + 24);
    drain("drain_c");
    chk("c_err", 64'(n_err), 64'd1);
    chk("c_done", 64'(n_done), 64'd3);

    // Random sparse traffic with random backpressure
    clear_counts();
    rdy_pct = 90;
    repeat (1500) begin
      v = ($urandom_range(99) < 40);
      drive(v, $urandom, v, $urandom);
    end
    drain("drain_r");
    chk("r_done", 64'(n_done), 64'd0);
    chk("r_err", 64'(n_err), 64'd0);
    chk("r_skew", 64'(n_skew), 64'd0);
    chk("r_ovf", 64'(lane_ovf), 64'd0);

    // Stall: only FIFO_DEPTH + 1 pairs survive
    rdy_pct = 0;
    for (int i = 0; i < 20; i++) begin
      accept = (i < 9);
      drive(1'b1, $urandom, 1'b1, $urandom);
    end
    accept = 1'b1;
    chk("d_ovf", 64'(lane_ovf), 64'd3);
    chk("d_valid", 64'(sample_valid), 64'd1);
    drain("drain_d");

    // Asynchronous reset with data in flight
    rdy_pct = 0;
    repeat (6) drive(1'b1, $urandom, 1'b1, $urandom);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("e_valid_pre", 64'(sample_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("e_valid", 64'(sample_valid), 64'd0);
    chk("e_out", sample_out, 64'd0);
    chk("e_ovf", 64'(lane_ovf), 64'd0);
    chk("e_count", 64'(burst_count), 64'd0);
    chk("e_idx", 64'(dbg_sample_idx), 64'd0);
    chk("e_pulses", 64'({skew_err, burst_done, burst_err}), 64'd0);
    lq1.delete();
    lq2.delete();
    exp_data.delete();
    exp_idx_q.delete();
    exp_idx = 0;
    cyc();
    cyc();
    rst = 1'b0;
    rdy_pct = 100;
    drive(1'b1, $urandom, 1'b1, $urandom);
    drain("drain_e");

    // Sample index wrap
    clear_counts();
    burst(int'(TS) + 2);
    drain("drain_f");
    chk("f_last_idx", 64'(dbg_sample_idx), 64'd2);
    chk("f_done", 64'(n_done), 64'd0);
    chk("f_ovf", 64'(lane_ovf), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
